fm_cmn_burst_drain: RTL and testbench
=====================================

# fm_cmn_burst_drain

Burst drain controller for the common block-RAM FIFO. It watches the FIFO fill count and launches a bus write burst when enough data is buffered, when an idle timeout expires, or when a flush is requested. It then streams exactly the announced number of words out of the FIFO's first-word-fall-through read port. It sits between a producer-side FIFO and the memory/bus write master, and is the only reader of that FIFO.

## Interface
Parameters:
- P_WIDTH, 32, data word width (matches FIFO).
- P_RANGE, 8, FIFO address width; FIFO depth is 2^P_RANGE.
- P_BLEN_W, 6, width of burst length fields.
- P_TO_W, 8, width of timeout field.

Ports (reset rst_x, asynchronous, active-low; clock clk_core):
- clk_core  in  1  system clock.
- rst_x  in  1  asynchronous active-low reset.
- i_enable  in  1  allows new bursts to launch.
- i_burst_len  in  P_BLEN_W  threshold and maximum burst length; 0 is treated as 1.
- i_timeout  in  P_TO_W  idle cycles before a partial burst; 0 disables the timeout.
- i_flush  in  1  pulse; drains all buffered words.
- i_fifo_dnum  in  P_RANGE+1  FIFO fill count.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_dt  in  P_WIDTH  FIFO head word, combinational.
- o_fifo_renable  out  1  FIFO pop.
- o_req  out  1  burst request.
- o_len  out  P_BLEN_W  burst length for the current request.
- i_ack  in  1  request accepted.
- o_wdata_strobe  out  1  write data valid.
- o_wdata  out  P_WIDTH  write data.
- i_wdata_ack  in  1  write data beat accepted.
- o_busy  out  1  a burst is in progress (REQ or DATA state).
- o_done  out  1  one-cycle pulse after the last beat.

## Operation
- FSM states: IDLE, REQ, DATA.
- Effective length: eff_len = (i_burst_len == 0) ? 1 : i_burst_len.
- Comparisons between i_fifo_dnum and eff_len are done at width max(P_RANGE+1, P_BLEN_W), zero-extended.

Launch conditions, evaluated in IDLE, only while i_enable=1 and i_fifo_empty=0, in priority order:
- Threshold: when i_fifo_dnum >= eff_len, len = eff_len.
- Flush: when the flush flag is set, len = min(i_fifo_dnum, eff_len).
- Timeout: when i_timeout != 0 and the timeout counter == i_timeout, len = min(i_fifo_dnum, eff_len).

On launch:
- Latch len into o_len and the beat counter.
- Clear the timeout counter.
- Go to REQ.

Timeout counter:
- Increments by 1 each IDLE cycle while i_fifo_empty=0 and i_enable=1, saturating at all-ones.
- Clears when the FIFO is empty, when i_enable=0, and on launch.

Flush flag:
- Set by an i_flush pulse in any state.
- Cleared in IDLE when i_fifo_empty=1.
- Repeated flush-triggered bursts continue until the FIFO is empty.

REQ state:
- o_req=1 and o_len is held stable.
- On i_ack=1, go to DATA.

DATA state:
- o_wdata_strobe=1 and o_wdata = i_fifo_dt.
- o_fifo_renable = i_wdata_ack, combinational.
- Each acked beat decrements the beat counter.
- The ack of the beat with counter == 1 moves the FSM to IDLE.
- The FIFO cannot underflow because len <= fill count at launch and this block is the only reader.

Other behaviour:
- i_enable=0 during REQ or DATA does not abort; the burst completes.
- When i_burst_len > 2^P_RANGE, the threshold is unreachable; data drains only via timeout or flush.
- i_burst_len changes after launch have no effect on the current burst.

## Timing
- Reset values: state IDLE; o_req, o_len, o_wdata_strobe, o_fifo_renable, o_busy, o_done all 0. o_wdata is 0 while not in DATA. Beat counter, timeout counter and flush flag are all 0.
- Reset asserted mid-burst: immediately return to the reset values. The FIFO is not touched; the remaining words stay buffered.
- Launch condition true at cycle t: o_req=1 at t+1.
- i_ack=1 at cycle t: o_req=0 and o_wdata_strobe=1 at t+1. Acks take effect in the same cycle.
- One beat per cycle at most. Back-to-back acks give a full-rate burst of len cycles.
- Last beat acked at cycle t: IDLE and o_done=1 at t+1. The earliest next o_req is t+2.
- i_flush in the same cycle as a threshold launch: the flag is set and serviced after the current burst.

## Test plan
- Threshold burst: burst_len=4, timeout=0, push 4 words A..D. Required: o_req one cycle after dnum=4, o_len=4. With i_ack and continuous i_wdata_ack, o_wdata = A,B,C,D on 4 consecutive cycles, then o_done for 1 cycle; FIFO empty.
- Timeout: burst_len=8, timeout=5, push 3 words. Required: o_req exactly 6 IDLE cycles after the first word arrives (counter reaches 5), o_len=3.
- Flush: burst_len=4, push 10 words, pulse i_flush. Required: bursts of lengths 4, 4, 2 in order, with data in FIFO order. The flag clears after the FIFO empties and no further o_req follows.
- Backpressure: len=4 with i_wdata_ack toggling 1,0,1,0,… Required: o_wdata holds during ack=0; 4 pops total; o_done 1 cycle after the 4th ack.
- Enable and reset: drop i_enable in DATA; the burst finishes and no new o_req appears while dnum>=len. Then reassert i_enable and assert rst_x mid-DATA: all outputs are 0 immediately, and after release a fresh burst starts from the remaining FIFO contents.
- Edge values: burst_len=0 is treated as 1, so single-word bursts occur. burst_len=63 with P_RANGE=4 never triggers on threshold; drain happens only via timeout.

Source files
------------

// File: rtl/fm_cmn_burst_drain.sv
// fm_cmn_burst_drain
// Burst drain controller for the common block-RAM FIFO. It watches the FIFO
// fill count and launches a write burst when the fill count reaches the
// burst length, when an idle timeout expires, or when a flush is pending.
// It then streams exactly the announced number of words out of the FIFO's
// first-word-fall-through read port. This block is the only FIFO reader.
//
// Ports:
//   clk_core        system clock
//   rst_x           asynchronous active-low reset
//   i_enable        allows new bursts to launch (a running burst always completes)
//   i_burst_len     threshold and maximum burst length (0 behaves as 1)
//   i_timeout       idle cycles before a partial burst (0 disables)
//   i_flush         pulse; drain everything currently buffered
//   i_fifo_dnum     FIFO fill count
//   i_fifo_empty    FIFO empty flag
//   i_fifo_dt       FIFO head word (combinational)
//   o_fifo_renable  FIFO pop, follows i_wdata_ack during DATA
//   o_req / o_len   burst request and its length, held until i_ack
//   i_ack           request accepted
//   o_wdata_strobe  write data valid
//   o_wdata         write data (0 outside DATA)
//   i_wdata_ack     write data beat accepted
//   o_busy          burst in progress (REQ or DATA)
//   o_done          one-cycle pulse after the last beat
module fm_cmn_burst_drain #(
  parameter int P_WIDTH  = 32,
  parameter int P_RANGE  = 8,
  parameter int P_BLEN_W = 6,
  parameter int P_TO_W   = 8
) (
  input  logic                clk_core,
  input  logic                rst_x,
  input  logic                i_enable,
  input  logic [P_BLEN_W-1:0] i_burst_len,
  input  logic [P_TO_W-1:0]   i_timeout,
  input  logic                i_flush,
  input  logic [P_RANGE:0]    i_fifo_dnum,
  input  logic                i_fifo_empty,
  input  logic [P_WIDTH-1:0]  i_fifo_dt,
  output logic                o_fifo_renable,
  output logic                o_req,
  output logic [P_BLEN_W-1:0] o_len,
  input  logic                i_ack,
  output logic                o_wdata_strobe,
  output logic [P_WIDTH-1:0]  o_wdata,
  input  logic                i_wdata_ack,
  output logic                o_busy,
  output logic                o_done
);

  // Fill count and burst length are compared at the wider of the two widths
  // so neither side gets truncated.
  localparam int CMP_W = (P_RANGE + 1 > P_BLEN_W) ? (P_RANGE + 1) : P_BLEN_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [P_BLEN_W-1:0] eff_len;
  logic [CMP_W-1:0]    dnum_ext;
  logic [CMP_W-1:0]    eff_ext;
  logic [CMP_W-1:0]    min_ext;
  logic                thr_hit;
  logic                to_hit;
  logic                can_launch;
  logic                launch;
  logic                beat_ack;
  logic                last_beat;

  logic [P_BLEN_W-1:0] len_q;
  logic [P_BLEN_W-1:0] beat_cnt_q;
  logic [P_TO_W-1:0]   to_cnt_q;
  logic                flush_q;
  logic                done_q;

  // Launch decision. min(dnum, eff_len) is the burst length for every launch
  // reason: on a threshold hit it equals eff_len, and when the threshold is
  // not reached dnum is below eff_len, so it fits in P_BLEN_W bits.
  always_comb begin
    eff_len    = (i_burst_len == '0) ? P_BLEN_W'(1) : i_burst_len;
    dnum_ext   = CMP_W'(i_fifo_dnum);
    eff_ext    = CMP_W'(eff_len);
    thr_hit    = (dnum_ext >= eff_ext);
    min_ext    = thr_hit ? eff_ext : dnum_ext;
    to_hit     = (i_timeout != '0) && (to_cnt_q == i_timeout);
    can_launch = (state_q == ST_IDLE) && i_enable && !i_fifo_empty;
    launch     = can_launch && (thr_hit || flush_q || to_hit);
    beat_ack   = (state_q == ST_DATA) && i_wdata_ack;
    last_beat  = beat_ack && (beat_cnt_q == P_BLEN_W'(1));
  end

  // State register.
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a started burst always runs to its last beat,
  // regardless of i_enable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch)    state_d = ST_REQ;
      ST_REQ:  if (i_ack)     state_d = ST_DATA;
      ST_DATA: if (last_beat) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output logic. The FIFO is first-word-fall-through, so the head word is
  // presented directly and popped in the same cycle the beat is accepted.
  always_comb begin
    o_req          = (state_q == ST_REQ);
    o_len          = len_q;
    o_wdata_strobe = (state_q == ST_DATA);
    o_wdata        = (state_q == ST_DATA) ? i_fifo_dt : '0;
    o_fifo_renable = beat_ack;
    o_busy         = (state_q != ST_IDLE);
    o_done         = done_q;
  end

  // Burst length and beat counter, both loaded at launch so later changes of
  // i_burst_len cannot disturb the running burst.
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else if (launch) begin
      len_q      <= P_BLEN_W'(min_ext);
      beat_cnt_q <= P_BLEN_W'(min_ext);
    end else if (beat_ack) begin
      beat_cnt_q <= beat_cnt_q - P_BLEN_W'(1);
    end
  end

  // Idle timeout counter: counts waiting IDLE cycles with data present and
  // saturates. Outside IDLE it is held at zero, which matches the cleared
  // value it had at launch.
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      to_cnt_q <= '0;
    end else if ((state_q != ST_IDLE) || i_fifo_empty || !i_enable || launch) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_q <= to_cnt_q + P_TO_W'(1);
    end
  end

  // Flush flag: a new pulse wins over clearing, so a flush that arrives with
  // the FIFO momentarily empty is still honoured for later data.
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      flush_q <= 1'b0;
    end else if (i_flush) begin
      flush_q <= 1'b1;
    end else if ((state_q == ST_IDLE) && i_fifo_empty) begin
      flush_q <= 1'b0;
    end
  end

  // Done pulse, one cycle after the last accepted beat.
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_beat;
    end
  end

endmodule

// File: tb/tb_fm_cmn_burst_drain.sv
// tb_fm_cmn_burst_drain
// Bench for fm_cmn_burst_drain. A queue stands in for the FWFT FIFO, and a
// transaction-level model (pending request flag + remaining beat count)
// predicts every output each cycle. Hand-computed literals pin cycle
// positions, burst lengths and data order for each directed scenario.
// The DUT uses P_RANGE=4 (16-deep FIFO) so that burst_len=63 is unreachable.
module tb_fm_cmn_burst_drain;

  localparam int W     = 32;
  localparam int R     = 4;
  localparam int BL    = 6;
  localparam int TO    = 8;
  localparam int DEPTH = 16;

  logic          clk_core = 1'b0;
  logic          rst_x;
  logic          i_enable;
  logic [BL-1:0] i_burst_len;
  logic [TO-1:0] i_timeout;
  logic          i_flush;
  logic [R:0]    i_fifo_dnum;
  logic          i_fifo_empty;
  logic [W-1:0]  i_fifo_dt;
  logic          o_fifo_renable;
  logic          o_req;
  logic [BL-1:0] o_len;
  logic          i_ack;
  logic          o_wdata_strobe;
  logic [W-1:0]  o_wdata;
  logic          i_wdata_ack;
  logic          o_busy;
  logic          o_done;

  fm_cmn_burst_drain #(
    .P_WIDTH (W),
    .P_RANGE (R),
    .P_BLEN_W(BL),
    .P_TO_W  (TO)
  ) dut (
    .clk_core      (clk_core),
    .rst_x         (rst_x),
    .i_enable      (i_enable),
    .i_burst_len   (i_burst_len),
    .i_timeout     (i_timeout),
    .i_flush       (i_flush),
    .i_fifo_dnum   (i_fifo_dnum),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_dt     (i_fifo_dt),
    .o_fifo_renable(o_fifo_renable),
    .o_req         (o_req),
    .o_len         (o_len),
    .i_ack         (i_ack),
    .o_wdata_strobe(o_wdata_strobe),
    .o_wdata       (o_wdata),
    .i_wdata_ack   (i_wdata_ack),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk_core = ~clk_core;

  // FIFO stand-in and push request for the current cycle.
  logic [W-1:0] fifo_q[$];
  bit           push_en;
  logic [W-1:0] push_data;
  bit           pop_sample;

  // Behavioural model state.
  bit m_req;
  int m_beats;
  int m_len;
  bit m_done;
  int m_idle;
  bit m_flush;

  int checks;
  int failures;
  int cyc;

  // Logs of what the DUT actually did, checked against literals.
  int           req_len_log[$];
  int           req_cyc_log[$];
  logic [W-1:0] beat_log[$];
  int           pop_cyc_log[$];
  int           done_cyc_log[$];
  bit           prev_req;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifo();
    i_fifo_dnum  = (R + 1)'(fifo_q.size());
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_dt    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic clear_logs();
    req_len_log.delete();
    req_cyc_log.delete();
    beat_log.delete();
    pop_cyc_log.delete();
    done_cyc_log.delete();
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic checkOutput();
    logic [W-1:0] head;
    bit in_rst;
    bit e_req;
    bit e_str;
    head   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    in_rst = (rst_x !== 1'b1);
    e_req  = !in_rst && m_req;
    e_str  = !in_rst && !m_req && (m_beats > 0);
    check_eq("o_req", o_req, e_req);
    check_eq("o_len", o_len, in_rst ? 0 : m_len);
    check_eq("o_wdata_strobe", o_wdata_strobe, e_str);
    check_eq("o_wdata", o_wdata, e_str ? head : '0);
    check_eq("o_fifo_renable", o_fifo_renable, e_str && (i_wdata_ack === 1'b1));
    check_eq("o_busy", o_busy, e_req || e_str);
    check_eq("o_done", o_done, !in_rst && m_done);
    if (o_req === 1'b1 && !prev_req) begin
      req_len_log.push_back(int'(o_len));
      req_cyc_log.push_back(cyc);
    end
    prev_req = (o_req === 1'b1);
    if (o_fifo_renable === 1'b1) begin
      beat_log.push_back(o_wdata);
      pop_cyc_log.push_back(cyc);
    end
    if (o_done === 1'b1) done_cyc_log.push_back(cyc);
    pop_sample = (o_fifo_renable === 1'b1);
  endtask

  // Advance the model by one clock using the inputs of the cycle just ended,
  // then apply that cycle's pop and push to the FIFO.
  task automatic advance();
    int dn;
    int eff;
    bit str;
    bit idle;
    bit old_flush;
    dn = fifo_q.size();
    if (rst_x !== 1'b1) begin
      m_req = 0; m_beats = 0; m_len = 0; m_done = 0; m_idle = 0; m_flush = 0;
    end else begin
      str       = !m_req && (m_beats > 0);
      idle      = !m_req && (m_beats == 0);
      old_flush = m_flush;
      m_done    = str && i_wdata_ack && (m_beats == 1);
      if (i_flush) m_flush = 1;
      else if (idle && dn == 0) m_flush = 0;
      if (m_req) begin
        if (i_ack) m_req = 0;
        m_idle = 0;
      end else if (m_beats > 0) begin
        if (i_wdata_ack) m_beats--;
        m_idle = 0;
      end else begin
        eff = (i_burst_len == 0) ? 1 : int'(i_burst_len);
        if (i_enable && dn > 0) begin
          if (dn >= eff || old_flush || (i_timeout != 0 && m_idle == int'(i_timeout))) begin
            m_len   = (dn < eff) ? dn : eff;
            m_req   = 1;
            m_beats = m_len;
            m_idle  = 0;
          end else if (m_idle < 255) begin
            m_idle++;
          end
        end else begin
          m_idle = 0;
        end
      end
    end
    if (pop_sample && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (push_en && fifo_q.size() < DEPTH) fifo_q.push_back(push_data);
    drive_fifo();
  endtask

  task automatic cycle();
    #2;
    checkOutput();
    @(posedge clk_core);
    @(negedge clk_core);
    cyc++;
    advance();
    push_en = 0;
    i_flush = 1'b0;
  endtask

  task automatic applyStimulus(input bit push, input logic [W-1:0] data, input bit flush);
    push_en   = push;
    push_data = data;
    i_flush   = flush;
    cycle();
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, '0, 0);
  endtask

  task automatic wait_strobe(input int budget);
    int k;
    k = 0;
    while (!(m_req == 0 && m_beats > 0) && k < budget) begin
      applyStimulus(0, '0, 0);
      k++;
    end
    check_eq("wait_strobe_bound", (k < budget), 1);
  endtask

  task automatic check_beats(input string name, input logic [W-1:0] base, input int n);
    check_eq({name, "_count"}, beat_log.size(), n);
    for (int i = 0; i < n && i < beat_log.size(); i++)
      check_eq(name, beat_log[i], base + W'(i));
  endtask

  initial begin
    int p;
    int e;
    rst_x       = 1'b0;
    i_enable    = 1'b1;
    i_burst_len = 6'd4;
    i_timeout   = 8'd0;
    i_flush     = 1'b0;
    i_ack       = 1'b1;
    i_wdata_ack = 1'b1;
    push_en     = 0;
    push_data   = '0;
    drive_fifo();
    @(negedge clk_core);

    // Reset values.
    run_idle(2);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_len", o_len, 0);
    rst_x = 1'b1;
    run_idle(2);

    // Threshold burst: 4 words, o_req two cycles after the 4th push.
    $display("[TB] threshold burst");
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      p = cyc;
      applyStimulus(1, 32'hAAAA_0000 + W'(i), 0);
    end
    run_idle(12);
    check_eq("thr_req_count", req_cyc_log.size(), 1);
    check_eq("thr_req_cycle", req_cyc_log[0], p + 2);
    check_eq("thr_len", req_len_log[0], 4);
    check_beats("thr_data", 32'hAAAA_0000, 4);
    check_eq("thr_done_cycle", done_cyc_log[0], p + 7);
    check_eq("thr_fifo_empty", fifo_q.size(), 0);

    // Timeout: 3 words, burst_len 8, timeout 5.
    $display("[TB] timeout burst");
    clear_logs();
    i_burst_len = 6'd8;
    i_timeout   = 8'd5;
    p = cyc;
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'hB000_0000 + W'(i), 0);
    run_idle(14);
    check_eq("to_req_count", req_cyc_log.size(), 1);
    check_eq("to_req_cycle", req_cyc_log[0], p + 7);
    check_eq("to_len", req_len_log[0], 3);
    check_beats("to_data", 32'hB000_0000, 3);

    // Flush: 10 words with burst_len 4 -> bursts 4, 4, 2.
    $display("[TB] flush bursts");
    clear_logs();
    i_burst_len = 6'd4;
    i_timeout   = 8'd0;
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'hC000_0000 + W'(i), (i == 9));
    run_idle(30);
    check_eq("fl_req_count", req_len_log.size(), 3);
    check_eq("fl_len0", req_len_log[0], 4);
    check_eq("fl_len1", req_len_log[1], 4);
    check_eq("fl_len2", req_len_log[2], 2);
    check_beats("fl_data", 32'hC000_0000, 10);
    applyStimulus(1, 32'hC000_00FF, 0);
    run_idle(10);
    check_eq("fl_cleared_no_req", req_len_log.size(), 3);
    applyStimulus(0, '0, 1);
    run_idle(8);
    check_eq("fl_single_req", req_len_log.size(), 4);
    check_eq("fl_single_len", req_len_log[3], 1);
    check_eq("fl_fifo_empty", fifo_q.size(), 0);

    // Backpressure: i_wdata_ack toggles 1,0,1,0,...
    $display("[TB] backpressure");
    clear_logs();
    for (int k = 0; k < 20; k++) begin
      i_wdata_ack = (k % 2 == 0);
      applyStimulus(k < 4, 32'hE000_0000 + W'(k), 0);
    end
    i_wdata_ack = 1'b1;
    run_idle(4);
    check_beats("bp_data", 32'hE000_0000, 4);
    check_eq("bp_pops", pop_cyc_log.size(), 4);
    check_eq("bp_done_count", done_cyc_log.size(), 1);
    check_eq("bp_done_after_last", done_cyc_log[0] - pop_cyc_log[3], 1);

    // Enable drop mid-burst, then reset mid-burst.
    $display("[TB] enable and reset");
    clear_logs();
    i_enable = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'h5000_0000 + W'(i), 0);
    run_idle(3);
    check_eq("en_off_no_req", req_len_log.size(), 0);
    i_enable = 1'b1;
    wait_strobe(10);
    i_enable = 1'b0;
    run_idle(15);
    check_eq("en_req_count", req_len_log.size(), 1);
    check_beats("en_data", 32'h5000_0000, 4);
    check_eq("en_fifo_left", fifo_q.size(), 6);
    clear_logs();
    i_enable = 1'b1;
    wait_strobe(10);
    applyStimulus(0, '0, 0);
    applyStimulus(0, '0, 0);
    rst_x = 1'b0;
    #2;
    check_eq("rst_mid_strobe", o_wdata_strobe, 0);
    check_eq("rst_mid_busy", o_busy, 0);
    check_eq("rst_mid_wdata", o_wdata, 0);
    run_idle(2);
    check_eq("rst_beats_before", beat_log.size(), 2);
    check_eq("rst_fifo_kept", fifo_q.size(), 4);
    rst_x = 1'b1;
    clear_logs();
    run_idle(15);
    check_eq("post_rst_req_count", req_len_log.size(), 1);
    check_eq("post_rst_len", req_len_log[0], 4);
    check_beats("post_rst_data", 32'h5000_0006, 4);

    // burst_len 0 behaves as single-word bursts.
    $display("[TB] edge values");
    clear_logs();
    i_burst_len = 6'd0;
    p = cyc;
    applyStimulus(1, 32'hF000_0000, 0);
    applyStimulus(1, 32'hF000_0001, 0);
    run_idle(10);
    check_eq("bl0_req_count", req_len_log.size(), 2);
    check_eq("bl0_len0", req_len_log[0], 1);
    check_eq("bl0_len1", req_len_log[1], 1);
    check_eq("bl0_req0_cycle", req_cyc_log[0], p + 2);
    check_eq("bl0_req1_cycle", req_cyc_log[1], p + 5);
    check_beats("bl0_data", 32'hF000_0000, 2);

    // burst_len 63 exceeds the 16-deep FIFO: only the timeout drains.
    clear_logs();
    i_burst_len = 6'd63;
    i_timeout   = 8'd3;
    i_enable    = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'hD000_0000 + W'(i), 0);
    i_enable = 1'b1;
    e = cyc;
    run_idle(15);
    check_eq("bl63_req_count", req_len_log.size(), 1);
    check_eq("bl63_req_cycle", req_cyc_log[0], e + 4);
    check_eq("bl63_len", req_len_log[0], 5);
    check_beats("bl63_data", 32'hD000_0000, 5);
    check_eq("bl63_fifo_empty", fifo_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
